// File: rtl/gb_cpu_common_pkg.sv
// Shared types and opcode constants for the CPU front end.
// Instruction-register state encoding and the special opcodes it recognises.
package gb_cpu_common_pkg;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    CB_PEND = 2'd1,
    HALT    = 2'd2
  } ir_state_t;

  localparam logic [7:0] OPC_NOP = 8'h00;
  localparam logic [7:0] OPC_CB  = 8'hCB;

endpackage

// File: rtl/gb_cpu_ir.sv
// Instruction register: latches fetched opcodes, tracks the CB prefix page,
// injects interrupt dispatch and implements HALT, including the HALT bug.
module gb_cpu_ir
  import gb_cpu_common_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] mem_rdata,
  input  logic       fetch_en,
  input  logic       ime,
  input  logic       int_pending,
  input  logic       halt_req,
  output logic [7:0] opcode,
  output logic       cb_prefix,
  output logic       isr_cmd,
  output logic       pc_inc,
  output logic       halted
);

  ir_state_t  state_q, state_d;
  logic [7:0] opcode_q, opcode_d;
  logic       cb_q, cb_d;
  logic       isr_q, isr_d;
  logic       halted_q, halted_d;
  logic       bug_q, bug_d;
  logic       isr_take;

  assign isr_take = (state_q == FETCH) && fetch_en && int_pending && ime;
  assign pc_inc   = fetch_en & ~halted_q & ~isr_take & ~bug_q;

  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    cb_d     = cb_q;
    isr_d    = isr_q;
    halted_d = halted_q;
    bug_d    = bug_q;

    unique case (state_q)
      FETCH: begin
        if (fetch_en) begin
          bug_d = 1'b0;
          cb_d  = 1'b0;
          if (isr_take) begin
            opcode_d = OPC_NOP;
            isr_d    = 1'b1;
          end else begin
            opcode_d = mem_rdata;
            isr_d    = 1'b0;
            if (mem_rdata == OPC_CB) state_d = CB_PEND;
          end
        end
      end
      CB_PEND: begin
        if (fetch_en) begin
          bug_d    = 1'b0;
          opcode_d = mem_rdata;
          cb_d     = 1'b1;
          isr_d    = 1'b0;
          state_d  = FETCH;
        end
      end
      HALT: begin
        if (int_pending) begin
          state_d  = FETCH;
          halted_d = 1'b0;
          if (ime) begin
            opcode_d = OPC_NOP;
            cb_d     = 1'b0;
            isr_d    = 1'b1;
          end
        end
      end
      default: state_d = FETCH;
    endcase

    // Halt is evaluated against the post-fetch state so a same-cycle fetch wins.
    if (halt_req && (state_q != HALT) && (state_d == FETCH)) begin
      if (int_pending && !ime) begin
        bug_d = 1'b1;
      end else begin
        state_d  = HALT;
        halted_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= FETCH;
      opcode_q <= OPC_NOP;
      cb_q     <= 1'b0;
      isr_q    <= 1'b0;
      halted_q <= 1'b0;
      bug_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      cb_q     <= cb_d;
      isr_q    <= isr_d;
      halted_q <= halted_d;
      bug_q    <= bug_d;
    end
  end

  assign opcode    = opcode_q;
  assign cb_prefix = cb_q;
  assign isr_cmd   = isr_q;
  assign halted    = halted_q;

endmodule

// File: tb/tb_gb_cpu_ir.sv
// Self-checking bench for gb_cpu_ir: directed scenarios plus randomized traffic
// checked against a behavioural model of the instruction register.
module tb_gb_cpu_ir;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] mem_rdata;
  logic       fetch_en, ime, int_pending, halt_req;
  logic [7:0] opcode;
  logic       cb_prefix, isr_cmd, pc_inc, halted;

  int n_cmp = 0;
  int n_err = 0;
  logic last_pc;

  // Model: mode 0 = normal fetch, 1 = prefix byte pending, 2 = halted.
  int       m_mode;
  bit [7:0] m_op;
  bit       m_cb, m_isr, m_halted, m_bug;

  always #5 clk = ~clk;

  gb_cpu_ir dut (
    .clk        (clk),
    .reset      (reset),
    .mem_rdata  (mem_rdata),
    .fetch_en   (fetch_en),
    .ime        (ime),
    .int_pending(int_pending),
    .halt_req   (halt_req),
    .opcode     (opcode),
    .cb_prefix  (cb_prefix),
    .isr_cmd    (isr_cmd),
    .pc_inc     (pc_inc),
    .halted     (halted)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge(input bit rst, input bit fe, input bit ie, input bit ip,
                            input bit hr, input bit [7:0] d);
    if (rst) begin
      m_mode = 0; m_op = 8'h00; m_cb = 0; m_isr = 0; m_halted = 0; m_bug = 0;
    end else if (m_mode == 2) begin
      if (ip) begin
        m_mode = 0;
        m_halted = 0;
        if (ie) begin m_op = 8'h00; m_isr = 1; m_cb = 0; end
      end
    end else begin
      if (fe) begin
        m_bug = 0;
        if (m_mode == 1) begin
          m_op = d; m_cb = 1; m_isr = 0; m_mode = 0;
        end else if (ip && ie) begin
          m_op = 8'h00; m_cb = 0; m_isr = 1;
        end else begin
          m_op = d; m_cb = 0; m_isr = 0;
          if (d == 8'hCB) m_mode = 1;
        end
      end
      if (hr && m_mode == 0) begin
        if (ip && !ie) m_bug = 1;
        else begin m_mode = 2; m_halted = 1; end
      end
    end
  endtask

  // One clock: drive at negedge, check pc_inc, clock, check registered outputs.
  task automatic cycle(input bit rst, input bit fe, input bit ie, input bit ip,
                       input bit hr, input bit [7:0] d);
    bit exp_pc;
    @(negedge clk);
    reset = rst; fetch_en = fe; ime = ie; int_pending = ip; halt_req = hr; mem_rdata = d;
    #1;
    exp_pc = fe && !m_halted && !m_bug && !(m_mode == 0 && ip && ie);
    last_pc = pc_inc;
    if (!rst) check("pc_inc", {31'd0, pc_inc}, {31'd0, exp_pc});
    model_edge(rst, fe, ie, ip, hr, d);
    @(posedge clk);
    #1;
    check("opcode", {24'd0, opcode}, {24'd0, m_op});
    check("cb_prefix", {31'd0, cb_prefix}, {31'd0, m_cb});
    check("isr_cmd", {31'd0, isr_cmd}, {31'd0, m_isr});
    check("halted", {31'd0, halted}, {31'd0, m_halted});
  endtask

  initial begin
    bit [7:0] d;
    reset = 1; fetch_en = 0; ime = 0; int_pending = 0; halt_req = 0; mem_rdata = 0;
    model_edge(1, 0, 0, 0, 0, 0);

    // Reset then plain fetch.
    cycle(1, 0, 0, 0, 0, 8'h00);
    check("rst_op", {24'd0, opcode}, 32'h00);
    check("rst_halted", {31'd0, halted}, 0);
    cycle(0, 1, 0, 0, 0, 8'h3E);
    check("f3e_pc", {31'd0, last_pc}, 1);
    check("f3e_op", {24'd0, opcode}, 32'h3E);
    check("f3e_cb", {31'd0, cb_prefix}, 0);

    // CB prefix blocks interrupts on the second byte.
    cycle(0, 1, 0, 0, 0, 8'hCB);
    check("cb1_op", {24'd0, opcode}, 32'hCB);
    cycle(0, 1, 1, 1, 0, 8'h37);
    check("cb2_op", {24'd0, opcode}, 32'h37);
    check("cb2_cb", {31'd0, cb_prefix}, 1);
    check("cb2_isr", {31'd0, isr_cmd}, 0);

    // ISR take.
    cycle(0, 1, 1, 1, 0, 8'hAF);
    check("isr_pc", {31'd0, last_pc}, 0);
    check("isr_op", {24'd0, opcode}, 32'h00);
    check("isr_cmd", {31'd0, isr_cmd}, 1);

    // HALT, ignored fetches, interrupt wake with dispatch.
    cycle(0, 0, 0, 0, 1, 8'h00);
    check("halt_set", {31'd0, halted}, 1);
    cycle(0, 1, 0, 0, 0, 8'h12);
    cycle(0, 1, 0, 0, 0, 8'h34);
    check("halt_hold_op", {24'd0, opcode}, 32'h00);
    check("halt_hold_pc", {31'd0, last_pc}, 0);
    cycle(0, 0, 1, 1, 0, 8'h00);
    check("wake_halted", {31'd0, halted}, 0);
    check("wake_isr", {31'd0, isr_cmd}, 1);

    // HALT bug: next fetch does not advance PC, the following one does.
    cycle(0, 0, 0, 1, 1, 8'h00);
    check("bug_halted", {31'd0, halted}, 0);
    cycle(0, 1, 0, 0, 0, 8'h55);
    check("bug_pc0", {31'd0, last_pc}, 0);
    cycle(0, 1, 0, 0, 0, 8'h55);
    check("bug_pc1", {31'd0, last_pc}, 1);

    // Reset in the middle of a prefix.
    cycle(0, 1, 0, 0, 0, 8'hCB);
    cycle(1, 0, 0, 0, 0, 8'h00);
    check("rstcb_cb", {31'd0, cb_prefix}, 0);
    check("rstcb_op", {24'd0, opcode}, 32'h00);
    cycle(0, 1, 0, 0, 0, 8'h37);
    check("rstcb_next_cb", {31'd0, cb_prefix}, 0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      d = ($urandom_range(0, 3) == 0) ? 8'hCB : 8'($urandom);
      cycle($urandom_range(0, 60) == 0, $urandom_range(0, 1) == 1,
            $urandom_range(0, 1) == 1, $urandom_range(0, 5) == 0,
            $urandom_range(0, 12) == 0, d);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
